jump_seq_ctrl: RTL and testbench
================================

Name: jump_seq_ctrl

Overview:
- Program-counter sequencer for the core; owns a writable 32-entry jump-target table indexed by the 5-bit jump pointer in branch instructions.
- Loads targets through a config port while idle and runs the program from Start to Halt.
- Supplies Prog_ctr to instruction fetch and reports Done to the testbench/top.
- Replaces the fixed per-program jump table, so one core runs any program without resynthesis.

Parameters:
- PC_W, 12, program-counter and jump-target width.
- PTR_W, 5, jump-pointer width.
- DEPTH, 32, number of table entries (must be at most 2**PTR_W).
- START_PC, 0, PC loaded on Start.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- Start  in  1  begin program execution (sampled in IDLE and DONE).
- Halt  in  1  decoded halt instruction.
- Stall  in  1  hold PC this cycle.
- Branch  in  1  decoded jump-table branch.
- BranchCond  in  1  branch condition from ALU flags.
- Jptr  in  PTR_W  jump-table index.
- Call  in  1  call via table (see optional feature).
- Ret  in  1  return (see optional feature).
- Cfg_we  in  1  table write strobe.
- Cfg_addr  in  PTR_W  table write index.
- Cfg_data  in  PC_W  table write value.
- Prog_ctr  out  PC_W  current PC.
- Jump  out  PC_W  combinational table[Jptr]; 0 if Jptr >= DEPTH.
- Busy  out  1  high in RUN.
- Done  out  1  one-cycle pulse on entering DONE.
- Cfg_err  out  1  sticky: config write attempted in RUN.
- Stack_err  out  1  sticky: stack over/underflow.

Behaviour:
- Reset, asynchronous: state IDLE; Prog_ctr=0; Busy, Done, Cfg_err and Stack_err all 0; all table entries 0; stack empty.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE with Start=1 -> RUN next edge:
  - Prog_ctr=START_PC.
  - Cfg_err and Stack_err cleared.
  - Stack emptied.
- Start while in RUN is ignored.
- RUN, evaluated per edge, highest priority first:
  - Stall: PC holds; Halt, Branch, Call and Ret are ignored.
  - Halt: -> DONE; PC holds; Done=1 for exactly the following cycle.
  - Branch & BranchCond: PC=Jump.
  - Branch & !BranchCond: PC=PC+1.
  - Otherwise: PC=PC+1, wrapping modulo 2**PC_W.
- DONE:
  - Done=1 for one cycle only.
  - State remains DONE until Start; PC holds.
  - Config writes are allowed.
- Config writes:
  - Cfg_we in IDLE/DONE writes table[Cfg_addr]=Cfg_data at the edge.
  - Writes with Cfg_addr >= DEPTH are dropped silently.
  - Cfg_we in RUN is ignored and sets Cfg_err.
- Cfg_we and Start in the same cycle: write commits, RUN starts, and a first-cycle branch sees the new value.
- Busy=1 exactly while state==RUN. Jump is purely combinational, with no added latency.

Optional Feature:
- JUMP_CALL_STACK_EN defined:
  - 4-deep return stack.
  - Call in RUN (not stalled, not halting) pushes PC+1 and sets PC=Jump; priority below Halt, above Branch.
  - Ret pops into PC; priority below Call.
  - Push when full: jump still taken, push dropped, Stack_err=1.
  - Ret when empty: PC=PC+1, Stack_err=1.
- Undefined:
  - Call behaves as Branch with BranchCond=1.
  - Ret is ignored.
  - Stack_err is tied 0.

Decomposition:
- jump_seq_pkg holds:
  - PC_W and PTR_W defaults.
  - seq_state_t enum (IDLE, RUN, DONE).
  - pc_t and jptr_t typedefs.
  - STACK_DEPTH=4.
- Sub-module jump_table: DEPTH x PC_W register file with one write port and one combinational read port, async reset to 0. The controller instantiates it.

Test Plan:
- Reset, then write table[3]=55; Start; at PC=2 drive Branch=1, BranchCond=1, Jptr=3 -> next cycle Prog_ctr=55, Busy=1.
- Branch=1, BranchCond=0 at PC=10 -> PC=11; run free to 4095 -> wraps to 0.
- Stall=1 together with Halt=1 -> PC holds and state stays RUN; release Stall with Halt=1 -> DONE, Done pulses exactly one cycle, Busy=0.
- Cfg_we during RUN with Cfg_addr=1, Cfg_data=99 -> table[1] unchanged, Cfg_err=1; Start from DONE -> Cfg_err=0, PC=START_PC.
- Assert Reset_n=0 mid-RUN at PC=40 -> immediately PC=0, state IDLE, table[3] reads 0.
- JUMP_CALL_STACK_EN: table[5]=100; Call Jptr=5 at PC=20 -> PC=100; Ret -> PC=21; five nested Calls -> Stack_err=1; Ret on empty stack -> PC+1, Stack_err=1.

Source files
------------

// File: rtl/jump_seq_pkg.sv
// Shared defaults, state type and stack sizing for the jump-table sequencer.
package jump_seq_pkg;

   localparam int unsigned DEF_PC_W    = 12;
   localparam int unsigned DEF_PTR_W   = 5;
   localparam int unsigned STACK_DEPTH = 4;
   localparam int unsigned SP_W        = $clog2(STACK_DEPTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } seq_state_t;

   typedef logic [DEF_PC_W-1:0]  pc_t;
   typedef logic [DEF_PTR_W-1:0] jptr_t;

endpackage

// File: rtl/jump_seq_ctrl_table.sv
// Jump-target register file: one write port, one combinational read port.
// Indices at or above DEPTH are never stored and read back as zero.
module jump_table
   import jump_seq_pkg::*;
#(
   parameter int unsigned PC_W  = DEF_PC_W,
   parameter int unsigned PTR_W = DEF_PTR_W,
   parameter int unsigned DEPTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [PTR_W-1:0] waddr,
   input  logic [PC_W-1:0]  wdata,
   input  logic [PTR_W-1:0] raddr,
   output logic [PC_W-1:0]  rdata
);

   logic [PC_W-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (we) begin
         for (int unsigned i = 0; i < DEPTH; i++)
            if (waddr == PTR_W'(i)) mem[i] <= wdata;
      end
   end

   always_comb begin
      rdata = '0;
      for (int unsigned i = 0; i < DEPTH; i++)
         if (raddr == PTR_W'(i)) rdata = mem[i];
   end

endmodule

// File: rtl/jump_seq_ctrl.sv
// Program-counter sequencer driven by a writable jump-target table.
// Define JUMP_CALL_STACK_EN to add the 4-deep call/return stack.
module jump_seq_ctrl
   import jump_seq_pkg::*;
#(
   parameter int unsigned PC_W     = DEF_PC_W,
   parameter int unsigned PTR_W    = DEF_PTR_W,
   parameter int unsigned DEPTH    = 32,
   parameter int unsigned START_PC = 0
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic             Halt,
   input  logic             Stall,
   input  logic             Branch,
   input  logic             BranchCond,
   input  logic [PTR_W-1:0] Jptr,
   input  logic             Call,
   input  logic             Ret,
   input  logic             Cfg_we,
   input  logic [PTR_W-1:0] Cfg_addr,
   input  logic [PC_W-1:0]  Cfg_data,
   output logic [PC_W-1:0]  Prog_ctr,
   output logic [PC_W-1:0]  Jump,
   output logic             Busy,
   output logic             Done,
   output logic             Cfg_err,
   output logic             Stack_err
);

   seq_state_t      state_q, state_next;
   logic [PC_W-1:0] pc_q, pc_next, pc_inc, jump_val;
   logic            done_q, done_next;
   logic            cfg_err_q, cfg_err_next;
   logic            tbl_we;

   jump_table #(
      .PC_W  (PC_W),
      .PTR_W (PTR_W),
      .DEPTH (DEPTH)
   ) u_table (
      .clk   (Clk),
      .rst_n (Reset_n),
      .we    (tbl_we),
      .waddr (Cfg_addr),
      .wdata (Cfg_data),
      .raddr (Jptr),
      .rdata (jump_val)
   );

   assign pc_inc = pc_q + PC_W'(1);

`ifdef JUMP_CALL_STACK_EN
   logic [PC_W-1:0] stack_q [STACK_DEPTH];
   logic [PC_W-1:0] stack_top;
   logic [SP_W-1:0] sp_q, sp_next;
   logic            push;
   logic            stack_err_q, stack_err_next;

   always_comb begin
      stack_top = '0;
      for (int unsigned i = 0; i < STACK_DEPTH; i++)
         if (sp_q == SP_W'(i + 1)) stack_top = stack_q[i];
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         sp_q        <= '0;
         stack_err_q <= 1'b0;
         for (int unsigned i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
      end else begin
         sp_q        <= sp_next;
         stack_err_q <= stack_err_next;
         if (push)
            for (int unsigned i = 0; i < STACK_DEPTH; i++)
               if (sp_q == SP_W'(i)) stack_q[i] <= pc_inc;
      end
   end

   assign Stack_err = stack_err_q;
`else
   logic unused_ret;
   assign unused_ret = Ret;
   assign Stack_err  = 1'b0;
`endif

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q   <= IDLE;
         pc_q      <= '0;
         done_q    <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_next;
         pc_q      <= pc_next;
         done_q    <= done_next;
         cfg_err_q <= cfg_err_next;
      end
   end

   always_comb begin
      state_next   = state_q;
      pc_next      = pc_q;
      done_next    = 1'b0;
      cfg_err_next = cfg_err_q;
      tbl_we       = 1'b0;
`ifdef JUMP_CALL_STACK_EN
      sp_next        = sp_q;
      push           = 1'b0;
      stack_err_next = stack_err_q;
`endif
      unique case (state_q)
         IDLE, DONE: begin
            // Table write and Start share the edge, so a first-cycle branch sees the new entry.
            tbl_we = Cfg_we;
            if (Start) begin
               state_next   = RUN;
               pc_next      = PC_W'(START_PC);
               cfg_err_next = 1'b0;
`ifdef JUMP_CALL_STACK_EN
               sp_next        = '0;
               stack_err_next = 1'b0;
`endif
            end
         end
         RUN: begin
            if (Cfg_we) cfg_err_next = 1'b1;
            if (Stall) begin
               pc_next = pc_q;
            end else if (Halt) begin
               state_next = DONE;
               done_next  = 1'b1;
            end
`ifdef JUMP_CALL_STACK_EN
            else if (Call) begin
               pc_next = jump_val;
               if (sp_q == SP_W'(STACK_DEPTH)) begin
                  stack_err_next = 1'b1;
               end else begin
                  push    = 1'b1;
                  sp_next = sp_q + SP_W'(1);
               end
            end else if (Ret) begin
               if (sp_q == '0) begin
                  pc_next        = pc_inc;
                  stack_err_next = 1'b1;
               end else begin
                  pc_next = stack_top;
                  sp_next = sp_q - SP_W'(1);
               end
            end
`endif
            else if (Call || (Branch && BranchCond)) begin
               pc_next = jump_val;
            end else begin
               pc_next = pc_inc;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign Prog_ctr = pc_q;
   assign Jump     = jump_val;
   assign Busy     = (state_q == RUN);
   assign Done     = done_q;
   assign Cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_jump_seq_ctrl.sv
// Self-checking bench for jump_seq_ctrl: directed vector table, corner sequences,
// and randomized traffic against a behavioural model (honours JUMP_CALL_STACK_EN).
module tb_jump_seq_ctrl;
   import jump_seq_pkg::*;

   localparam int unsigned PC_W     = 12;
   localparam int unsigned PTR_W    = 5;
   localparam int unsigned DEPTH    = 32;
   localparam int unsigned START_PC = 0;
   localparam int          PC_MOD   = 4096;

   logic             Clk = 1'b0;
   logic             Reset_n;
   logic             Start, Halt, Stall, Branch, BranchCond, Call, Ret, Cfg_we;
   logic [PTR_W-1:0] Jptr, Cfg_addr;
   logic [PC_W-1:0]  Cfg_data;
   logic [PC_W-1:0]  Prog_ctr, Jump;
   logic             Busy, Done, Cfg_err, Stack_err;

   always #5 Clk = ~Clk;

   jump_seq_ctrl #(
      .PC_W     (PC_W),
      .PTR_W    (PTR_W),
      .DEPTH    (DEPTH),
      .START_PC (START_PC)
   ) dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .Start      (Start),
      .Halt       (Halt),
      .Stall      (Stall),
      .Branch     (Branch),
      .BranchCond (BranchCond),
      .Jptr       (Jptr),
      .Call       (Call),
      .Ret        (Ret),
      .Cfg_we     (Cfg_we),
      .Cfg_addr   (Cfg_addr),
      .Cfg_data   (Cfg_data),
      .Prog_ctr   (Prog_ctr),
      .Jump       (Jump),
      .Busy       (Busy),
      .Done       (Done),
      .Cfg_err    (Cfg_err),
      .Stack_err  (Stack_err)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model: running flag, PC as an integer, table as an int array, stack as a queue.
   int m_tbl [DEPTH];
   int m_pc;
   bit m_run, m_done, m_cfg_err, m_stack_err;
   int m_stk [$];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int model_jump(input int idx);
      return (idx < int'(DEPTH)) ? m_tbl[idx] : 0;
   endfunction

   task automatic model_reset();
      foreach (m_tbl[i]) m_tbl[i] = 0;
      m_pc = 0; m_run = 0; m_done = 0; m_cfg_err = 0; m_stack_err = 0;
      m_stk.delete();
   endtask

   task automatic model_edge();
      int tgt;
      tgt    = model_jump(int'(Jptr));
      m_done = 0;
      if (!m_run) begin
         if (Cfg_we && int'(Cfg_addr) < int'(DEPTH)) m_tbl[int'(Cfg_addr)] = int'(Cfg_data);
         if (Start) begin
            m_run = 1; m_pc = int'(START_PC); m_cfg_err = 0; m_stack_err = 0;
            m_stk.delete();
         end
      end else begin
         if (Cfg_we) m_cfg_err = 1;
         if (Stall) begin
            // hold
         end else if (Halt) begin
            m_run = 0; m_done = 1;
         end
`ifdef JUMP_CALL_STACK_EN
         else if (Call) begin
            if (m_stk.size() >= int'(STACK_DEPTH)) m_stack_err = 1;
            else m_stk.push_back((m_pc + 1) % PC_MOD);
            m_pc = tgt;
         end else if (Ret) begin
            if (m_stk.size() == 0) begin
               m_stack_err = 1; m_pc = (m_pc + 1) % PC_MOD;
            end else m_pc = m_stk.pop_back();
         end
`endif
         else if (Call || (Branch && BranchCond)) m_pc = tgt;
         else m_pc = (m_pc + 1) % PC_MOD;
      end
   endtask

   task automatic drive(input bit st, hl, sl, br, bc, cl, rt, we, input int jp, ad, da);
      Start = st; Halt = hl; Stall = sl; Branch = br; BranchCond = bc;
      Call = cl; Ret = rt; Cfg_we = we;
      Jptr = PTR_W'(jp); Cfg_addr = PTR_W'(ad); Cfg_data = PC_W'(da);
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Called at posedge+1 with inputs already driven; leaves time at the next posedge+1.
   task automatic tick();
      #1;
      chk("jump", int'(Jump), model_jump(int'(Jptr)));
      model_edge();
      @(posedge Clk);
      #1;
      chk("prog_ctr", int'(Prog_ctr), m_pc);
      chk("busy", int'(Busy), int'(m_run));
      chk("done", int'(Done), int'(m_done));
      chk("cfg_err", int'(Cfg_err), int'(m_cfg_err));
      chk("stack_err", int'(Stack_err), int'(m_stack_err));
   endtask

   task automatic run_idle(input int n);
      idle();
      for (int k = 0; k < n; k++) tick();
   endtask

   typedef struct {
      bit start, halt, stall, branch, cond, call, we;
      int jptr, addr, data;
      int exp_jump, exp_pc;
      bit exp_busy, exp_done, exp_cfg_err;
   } vec_t;

   vec_t vecs [$];

   function automatic vec_t mk(input bit st, hl, sl, br, bc, cl, we, input int jp, ad, da,
                               input int ej, ep, input bit eb, ed, ee);
      vec_t v;
      v.start = st; v.halt = hl; v.stall = sl; v.branch = br; v.cond = bc; v.call = cl; v.we = we;
      v.jptr = jp; v.addr = ad; v.data = da;
      v.exp_jump = ej; v.exp_pc = ep; v.exp_busy = eb; v.exp_done = ed; v.exp_cfg_err = ee;
      return v;
   endfunction

   initial begin
      //                st hl sl br bc cl we jp ad  da   ej   ep  bsy dn err
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 3, 55,   0,   0,  0, 0, 0)); // idle write t[3]
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0,   0,  1, 0, 0)); // start
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0,   1,  1, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0,   2,  1, 0, 0)); // start ignored in RUN
      vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 3, 0, 0,   55,  55,  1, 0, 0)); // taken branch
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 3, 0, 0,   55,  56,  1, 0, 0)); // not taken
      vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0,    0,  56,  1, 0, 0)); // stall beats halt
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,    0,  56,  0, 1, 0)); // halt
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0,  56,  0, 0, 0)); // done pulse ends
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 7,    0,  56,  0, 0, 0)); // write in DONE
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0,    7,   0,  1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 99,   7,   1,  1, 0, 1)); // write in RUN
      vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1, 0, 0,    7,   7,  1, 0, 1)); // t[1] unchanged
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,    0,   7,  0, 1, 1));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0,   0,  1, 0, 0)); // start clears err
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,    0,   0,  0, 1, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 2, 2, 300,  0,   0,  1, 0, 0)); // write + start
      vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 2, 0, 0,  300, 300,  1, 0, 0)); // sees new entry
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 3, 0, 0,   55,  55,  1, 0, 0)); // call jumps
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,    0,  55,  0, 1, 0));

      idle();
      Reset_n = 1'b0;
      model_reset();
      #3;
      chk("rst_pc", int'(Prog_ctr), 0);
      chk("rst_busy", int'(Busy), 0);
      chk("rst_done", int'(Done), 0);
      chk("rst_cfg_err", int'(Cfg_err), 0);
      chk("rst_stack_err", int'(Stack_err), 0);
      chk("rst_jump", int'(Jump), 0);
      #4 Reset_n = 1'b1;
      @(posedge Clk);
      #1;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].start, vecs[i].halt, vecs[i].stall, vecs[i].branch, vecs[i].cond,
               vecs[i].call, 0, vecs[i].we, vecs[i].jptr, vecs[i].addr, vecs[i].data);
         #1;
         chk($sformatf("vec%0d_jump", i), int'(Jump), vecs[i].exp_jump);
         tick();
         chk($sformatf("vec%0d_pc", i), int'(Prog_ctr), vecs[i].exp_pc);
         chk($sformatf("vec%0d_busy", i), int'(Busy), int'(vecs[i].exp_busy));
         chk($sformatf("vec%0d_done", i), int'(Done), int'(vecs[i].exp_done));
         chk($sformatf("vec%0d_cfg_err", i), int'(Cfg_err), int'(vecs[i].exp_cfg_err));
      end

      // Not-taken branch at PC 10, then PC wrap past 4095.
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 4, 4094); tick();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);    tick();
      run_idle(10);
      chk("pc_at_10", int'(Prog_ctr), 10);
      drive(0, 0, 0, 1, 0, 0, 0, 0, 4, 0, 0);    tick();
      chk("branch_nt_pc", int'(Prog_ctr), 11);
      drive(0, 0, 0, 1, 1, 0, 0, 0, 4, 0, 0);    tick();
      chk("pc_4094", int'(Prog_ctr), 4094);
      run_idle(1);
      chk("pc_4095", int'(Prog_ctr), 4095);
      run_idle(1);
      chk("pc_wrap", int'(Prog_ctr), 0);

      // Asynchronous reset in the middle of RUN.
      run_idle(40);
      chk("pc_at_40", int'(Prog_ctr), 40);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
      #2 Reset_n = 1'b0;
      #1;
      model_reset();
      chk("arst_pc", int'(Prog_ctr), 0);
      chk("arst_busy", int'(Busy), 0);
      chk("arst_tbl3", int'(Jump), 0);
      chk("arst_cfg_err", int'(Cfg_err), 0);
      #3 Reset_n = 1'b1;

      // Call/return behaviour.
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 5, 100); tick();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);   tick();
      run_idle(20);
      chk("pc_at_20", int'(Prog_ctr), 20);
      drive(0, 0, 0, 0, 0, 1, 0, 0, 5, 0, 0);   tick();
      chk("call_pc", int'(Prog_ctr), 100);
      drive(0, 0, 0, 0, 0, 0, 1, 0, 5, 0, 0);   tick();
`ifdef JUMP_CALL_STACK_EN
      chk("ret_pc", int'(Prog_ctr), 21);
      for (int k = 0; k < 5; k++) begin
         drive(0, 0, 0, 0, 0, 1, 0, 0, 5, 0, 0); tick();
         chk($sformatf("nest%0d_err", k), int'(Stack_err), (k == 4) ? 1 : 0);
      end
      drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) tick();
      chk("unwind_pc", int'(Prog_ctr), 22);
      tick();
      chk("ret_empty_pc", int'(Prog_ctr), 23);
      chk("ret_empty_err", int'(Stack_err), 1);
`else
      chk("ret_ignored_pc", int'(Prog_ctr), 101);
      chk("stack_err_tied", int'(Stack_err), 0);
`endif
      drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);   tick();

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         drive($urandom_range(0, 99) < 8,  $urandom_range(0, 99) < 4,
               $urandom_range(0, 99) < 20, $urandom_range(0, 1) == 1,
               $urandom_range(0, 1) == 1,  $urandom_range(0, 99) < 10,
               $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 15,
               int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
               int'($urandom_range(0, 4095)));
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
